// File: rtl/tablero_pkg.sv
// Shared types and constants for the tic-tac-toe referee: game states,
// winning-line masks, board constants and the free-cell picker.
package tablero_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0000,
    ST_INIT    = 4'b0001,
    ST_P1_TURN = 4'b0010,
    ST_P2_TURN = 4'b0011,
    ST_CHECK   = 4'b0100,
    ST_P1_WIN  = 4'b0101,
    ST_P2_WIN  = 4'b0110,
    ST_DRAW    = 4'b0111
  } state_e;

  // Index i is win_line bit i: rows, then columns, then the two diagonals.
  localparam logic [7:0][8:0] LINE_MASKS = {
    9'h054, 9'h111,
    9'h049, 9'h092, 9'h124,
    9'h007, 9'h038, 9'h1C0
  };

  localparam int unsigned TURN_CYCLES_DEFAULT = 750_000_000;
  localparam logic [8:0]  BOARD_FULL          = 9'h1FF;
  localparam int          TIMER_W             = 30;

  function automatic logic [8:0] highest_free(input logic [8:0] occ);
    logic [8:0] pick;
    pick = '0;
    for (int i = 0; i < 9; i++) begin
      if (!occ[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tablero_line_checker.sv
// Combinational winning-line detector: one hit bit per line fully
// covered by the given player board.
module line_checker
  import tablero_pkg::*;
(
  input  logic [8:0] i_board,
  output logic [7:0] o_hits
);

  always_comb begin
    o_hits = '0;
    for (int i = 0; i < 8; i++) begin
      o_hits[i] = ((i_board & LINE_MASKS[i]) == LINE_MASKS[i]);
    end
  end

endmodule

// File: rtl/tablero_referee.sv
// Tic-tac-toe referee: validates proposed occupancy matrices, records moves,
// detects wins/draws. Optional turn timer enabled by TURN_TIMEOUT_EN.
module tablero_referee
  import tablero_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = TURN_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_n,
  input  logic       load,
  input  logic [8:0] matrix_in,
  output logic [3:0] current_state,
  output logic [8:0] occupied,
  output logic [8:0] p1_board,
  output logic [8:0] p2_board,
  output logic [7:0] win_line,
  output logic       accept,
  output logic       reject,
  output logic       timeout
);

  state_e     r_state, w_state_nxt;
  logic [8:0] r_p1, r_p2, w_p1_nxt, w_p2_nxt;
  logic [7:0] r_win_line, w_win_line_nxt;
  logic       r_last_player, w_last_player_nxt;
  logic       r_accept, r_reject, r_timeout;
  logic       w_accept_nxt, w_reject_nxt, w_timeout_nxt;

  logic [8:0] w_occupied, w_new, w_last_board;
  logic [7:0] w_hits;
  logic       w_valid, w_is_p2_turn, w_in_turn;

  assign w_occupied   = r_p1 | r_p2;
  assign w_new        = matrix_in & ~w_occupied;
  // A proposal must keep every occupied cell and add exactly one new one.
  assign w_valid      = load && (w_new != '0) && ((w_new & (w_new - 9'd1)) == '0)
                        && ((matrix_in & w_occupied) == w_occupied);
  assign w_is_p2_turn = (r_state == ST_P2_TURN);
  assign w_in_turn    = (r_state == ST_P1_TURN) || (r_state == ST_P2_TURN);
  assign w_last_board = r_last_player ? r_p2 : r_p1;

  line_checker u_line_checker (
    .i_board (w_last_board),
    .o_hits  (w_hits)
  );

`ifdef TURN_TIMEOUT_EN
  logic [TIMER_W-1:0] r_timer, w_timer_nxt;
  logic               w_expired;
  assign w_expired = (r_timer == TIMER_W'(TURN_CYCLES - 1));
`else
  logic w_unused_turn_cycles;
  assign w_unused_turn_cycles = ^TURN_CYCLES;
`endif

  // NOTE: every next-value signal gets a default before the case so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_p1_nxt          = r_p1;
    w_p2_nxt          = r_p2;
    w_win_line_nxt    = r_win_line;
    w_last_player_nxt = r_last_player;
    w_accept_nxt      = 1'b0;
    w_reject_nxt      = 1'b0;
    w_timeout_nxt     = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_P1_WIN, ST_P2_WIN, ST_DRAW: begin
        if (!start_n) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        w_p1_nxt          = '0;
        w_p2_nxt          = '0;
        w_win_line_nxt    = '0;
        w_last_player_nxt = 1'b0;
        w_state_nxt       = ST_P1_TURN;
      end
      ST_P1_TURN, ST_P2_TURN: begin
        if (w_valid) begin
          if (w_is_p2_turn) w_p2_nxt = r_p2 | w_new;
          else              w_p1_nxt = r_p1 | w_new;
          w_accept_nxt      = 1'b1;
          w_last_player_nxt = w_is_p2_turn;
          w_state_nxt       = ST_CHECK;
        end
`ifdef TURN_TIMEOUT_EN
        else if (w_expired) begin
          if (w_is_p2_turn) w_p2_nxt = r_p2 | highest_free(w_occupied);
          else              w_p1_nxt = r_p1 | highest_free(w_occupied);
          w_timeout_nxt     = 1'b1;
          w_last_player_nxt = w_is_p2_turn;
          w_state_nxt       = ST_CHECK;
        end
`endif
        else if (load) begin
          w_reject_nxt = 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_hits != '0) begin
          w_win_line_nxt = w_hits;
          w_state_nxt    = r_last_player ? ST_P2_WIN : ST_P1_WIN;
        end else if (w_occupied == BOARD_FULL) begin
          w_state_nxt = ST_DRAW;
        end else begin
          w_state_nxt = r_last_player ? ST_P1_TURN : ST_P2_TURN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef TURN_TIMEOUT_EN
  // Counts only while staying in a turn state; any entry starts from zero.
  always_comb begin
    w_timer_nxt = '0;
    if (w_in_turn && (w_state_nxt == r_state)) w_timer_nxt = r_timer + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_timer <= '0;
    else     r_timer <= w_timer_nxt;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_p1          <= '0;
      r_p2          <= '0;
      r_win_line    <= '0;
      r_last_player <= 1'b0;
      r_accept      <= 1'b0;
      r_reject      <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_p1          <= w_p1_nxt;
      r_p2          <= w_p2_nxt;
      r_win_line    <= w_win_line_nxt;
      r_last_player <= w_last_player_nxt;
      r_accept      <= w_accept_nxt;
      r_reject      <= w_reject_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign current_state = r_state;
  assign occupied      = w_occupied;
  assign p1_board      = r_p1;
  assign p2_board      = r_p2;
  assign win_line      = r_win_line;
  assign accept        = r_accept;
  assign reject        = r_reject;
  assign timeout       = r_timeout;

endmodule

// File: doc/tablero_referee.md
# tablero_referee

Game referee on the receiving end of the board-control `load`/matrix handshake in the tic-tac-toe VGA design. It accepts a proposed 9-bit occupancy matrix from the cursor/marking controller and validates that exactly one new cell was added. It records the move for the player whose turn it is, checks the eight winning lines, and advances the game state. It also drives `occupied` back to the controller as its `matrix_in`, and exports both player boards plus the game state to the VGA renderer.

## Interface
- `TURN_CYCLES`, default 750_000_000: per-turn timeout in clock cycles (15 s at 50 MHz); used only with the timeout feature.
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: synchronous reset, active-high.
- `start_n` input 1: start/restart button, active-low level.
- `load` input 1: move-proposal strobe from the board controller.
- `matrix_in` input 9: proposed occupancy matrix; bit 8 is top-left, bit 0 is bottom-right, row-major.
- `current_state` output 4: game state, encoded as below.
- `occupied` output 9: `p1_board | p2_board`, fed back to the controller.
- `p1_board` output 9: cells owned by player 1.
- `p2_board` output 9: cells owned by player 2.
- `win_line` output 8: one-hot set of completed lines; valid in the WIN states, otherwise 0.
- `accept` output 1: one-cycle pulse when a move is recorded.
- `reject` output 1: one-cycle pulse when a `load` is invalid.
- `timeout` output 1: one-cycle pulse when the turn timer forces a move.

## Operation
- State encoding:
  - IDLE=0000
  - INIT=0001
  - P1_TURN=0010
  - P2_TURN=0011
  - CHECK=0100
  - P1_WIN=0101
  - P2_WIN=0110
  - DRAW=0111
- IDLE, P1_WIN, P2_WIN and DRAW go to INIT when `start_n`=0 is sampled. In every other state `start_n` is ignored.
- INIT clears both boards, `win_line` and `last_player`, then goes to P1_TURN.
- Turn states compute `new = matrix_in & ~occupied`.
  - popcount(`new`)==1: OR `new` into the current player's board, pulse `accept`, latch `last_player`, go to CHECK.
  - Otherwise (0 bits, ≥2 bits, or a cleared occupied bit): pulse `reject`, boards unchanged, stay in the turn state.
- `load` in IDLE, INIT, CHECK or an end state is ignored: no pulse, no change.
- CHECK evaluates the lines on `last_player`'s board, in this priority order:
  - Any line hit: set `win_line`, go to P1_WIN or P2_WIN.
  - Else `occupied`==9'h1FF: go to DRAW.
  - Else: go to the opponent's turn.
- Lines:
  - Rows {8,7,6}, {5,4,3}, {2,1,0}: `win_line` bits 0–2.
  - Columns {8,5,2}, {7,4,1}, {6,3,0}: bits 3–5.
  - Diagonals {8,4,0}, {6,4,2}: bits 6–7.
- Multiple simultaneous lines are legal and all of their bits are set.

## Timing
- Reset: state IDLE; all boards, `win_line`, `accept`, `reject`, `timeout` and the timer are 0. Reset mid-game takes effect at the next edge with the same values.
- Valid `load` sampled at edge N:
  - Board and `accept` visible after N; state is CHECK.
  - Result state visible after N+1.
  - Decision latency is 2 cycles.
- `reject` is visible the cycle after the sampled `load`. A `load` held high for k turn-state cycles yields k evaluations. The controller pulses `load` for 1 cycle.
- `occupied` is combinational from the board registers, so there is no extra latency.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - A 30-bit timer clears on entry to P1_TURN/P2_TURN and increments each turn cycle.
  - When it reaches `TURN_CYCLES`-1 with no valid `load` that cycle, the referee places the current player's mark at the highest-index free cell, pulses `timeout` (not `accept`), and goes to CHECK.
  - A valid `load` in the same cycle as expiry wins; `timeout` is not pulsed.
- `TURN_TIMEOUT_EN` not defined: no timer, turns wait indefinitely, `timeout` is tied to 0.

## Structure
- Package `tablero_pkg`:
  - State enum (4-bit, values above).
  - Eight 9-bit line masks.
  - `TURN_CYCLES` default.
  - `BOARD_FULL`=9'h1FF.
- Sub-module `line_checker`: combinational, 9-bit board in → 8-bit `win_line` hits out. It is instantiated once and fed by a `last_player` mux.

## Test plan
- Reset, `start_n` low 1 cycle → INIT, then P1_TURN; `occupied`=0.
- P1 `load` with `matrix_in`=9'h100 → `accept`, `p1_board`=9'h100, CHECK, then P2_TURN.
- P2 `load` with `matrix_in`=9'h100 (no new bit) → `reject`, state stays P2_TURN. Then `matrix_in`=9'h180 → accepted.
- Two-bit proposal in a turn state → `reject`.
- P1 takes 8, 4, 0 interleaved with P2 moves → P1_WIN, `win_line`=8'h40. Further `load` is ignored.
- Full board with no line → DRAW. With `TURN_TIMEOUT_EN` and `TURN_CYCLES`=16, idle P1_TURN → `timeout` at cycle 16, mark placed at bit 8.
